// File: rtl/vscale_dmem_bridge_pkg.sv
// vscale_dmem_bridge_pkg
//   Shared constants for the data-memory bridge: core memory access types,
//   bridge FSM state encoding, byte-enable width and a word-align helper.
//   Imported by vscale_dmem_bridge_if, vscale_dmem_be_gen and vscale_dmem_bridge.
package vscale_dmem_bridge_pkg;

  // Core memory access types (same encoding as the pipeline control).
  // Stores reuse the signed load encodings for their size.
  localparam int                      MEM_TYPE_WIDTH = 3;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_LB  = 3'd0;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_LH  = 3'd1;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_LW  = 3'd2;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_LD  = 3'd3;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_LBU = 3'd4;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_LHU = 3'd5;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_LWU = 3'd6;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_SB  = MEM_TYPE_LB;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_SH  = MEM_TYPE_LH;
  localparam logic [MEM_TYPE_WIDTH-1:0] MEM_TYPE_SW  = MEM_TYPE_LW;

  localparam int DMB_XPR_LEN  = 32;
  localparam int DMB_BE_WIDTH = 4;

  typedef enum logic [1:0] {
    DMB_ST_IDLE = 2'd0,
    DMB_ST_REQ  = 2'd1,
    DMB_ST_RESP = 2'd2
  } dmb_state_e;

  function automatic logic [DMB_XPR_LEN-1:0] dmb_word_addr(input logic [DMB_XPR_LEN-1:2] hi);
    return {hi, 2'b00};
  endfunction

endpackage

// File: rtl/vscale_dmem_bridge_if.sv
// vscale_dmem_bridge_if
//   Request/grant/response data bus, single outstanding transaction.
//   master (bridge): bus_req, bus_we, bus_addr, bus_be, bus_wdata out;
//                    bus_gnt, bus_rvalid, bus_rdata, bus_err in.
//   slave  (memory): the mirror image.
//   bus_err is only meaningful while bus_rvalid is high.
interface vscale_dmem_bridge_if;
  import vscale_dmem_bridge_pkg::*;

  logic                    bus_req;
  logic                    bus_gnt;
  logic                    bus_we;
  logic [DMB_XPR_LEN-1:0]  bus_addr;
  logic [DMB_BE_WIDTH-1:0] bus_be;
  logic [DMB_XPR_LEN-1:0]  bus_wdata;
  logic                    bus_rvalid;
  logic [DMB_XPR_LEN-1:0]  bus_rdata;
  logic                    bus_err;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata, bus_err
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata, bus_err
  );

endinterface

// File: rtl/vscale_dmem_bridge_be_gen.sv
// vscale_dmem_be_gen
//   Combinational byte-enable generator.
//   i_wen     : access is a store
//   i_size    : core access type
//   i_addr_lo : byte address bits [1:0]
//   o_be      : bus byte enables; loads always fetch the full word
module vscale_dmem_be_gen
  import vscale_dmem_bridge_pkg::*;
(
  input  logic                      i_wen,
  input  logic [MEM_TYPE_WIDTH-1:0] i_size,
  input  logic [1:0]                i_addr_lo,
  output logic [DMB_BE_WIDTH-1:0]   o_be
);

  always_comb begin
    o_be = '1;
    if (i_wen) begin
      case (i_size)
        MEM_TYPE_LB, MEM_TYPE_LBU: o_be = 4'b0001 << i_addr_lo;
        MEM_TYPE_LH, MEM_TYPE_LHU: o_be = 4'b0011 << {i_addr_lo[1], 1'b0};
        default:                   o_be = '1;
      endcase
    end
  end

endmodule

// File: rtl/vscale_dmem_bridge.sv
// vscale_dmem_bridge
//   Turns the core's pipelined dmem port (address in DX, store data in WB)
//   into a single-outstanding req/gnt/rvalid bus, stalling the core with
//   o_dmem_wait and bounding every transaction with a watchdog.
//
//   Parameters: XPR_LEN (32), TIMEOUT_CYCLES (1..65535, cycles in REQ+RESP
//   before the access is forced to complete with an access fault).
//
//   Ports:
//     clk, reset             clock, synchronous active-high reset
//     i_dmem_en/wen/size     core address phase
//     i_dmem_addr            core byte address
//     i_dmem_wdata_delayed   store data, valid the cycle after the address
//     o_dmem_wait            core stall
//     o_dmem_rdata           raw word from the bus (core aligns/extends)
//     o_dmem_badmem_e        access fault, valid when o_dmem_wait=0
//     o_wr_err_sticky        posted-write error flag
//     bus                    vscale_dmem_bridge_if.master
//
//   Build option VSCALE_DMEM_POSTED_WR_EN: stores complete to the core on
//   grant; their response is tracked by a pending flag, and an error on it
//   sets o_wr_err_sticky. Without it stores wait for rvalid like loads and
//   o_wr_err_sticky is 0.
//
//   state | meaning
//   IDLE  | no access in flight
//   REQ   | bus_req asserted (or held off by a pending posted write)
//   RESP  | granted, waiting for bus_rvalid
module vscale_dmem_bridge
  import vscale_dmem_bridge_pkg::*;
#(
  parameter int XPR_LEN        = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_dmem_en,
  input  logic                      i_dmem_wen,
  input  logic [MEM_TYPE_WIDTH-1:0] i_dmem_size,
  input  logic [XPR_LEN-1:0]        i_dmem_addr,
  input  logic [XPR_LEN-1:0]        i_dmem_wdata_delayed,
  output logic                      o_dmem_wait,
  output logic [XPR_LEN-1:0]        o_dmem_rdata,
  output logic                      o_dmem_badmem_e,
  output logic                      o_wr_err_sticky,
  vscale_dmem_bridge_if.master      bus
);

  localparam int         TMO_W    = 16;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  dmb_state_e              r_state;
  dmb_state_e              w_state_nxt;
  logic [XPR_LEN-1:2]      r_addr_hi;
  logic                    r_wen;
  logic [DMB_BE_WIDTH-1:0] r_be;
  logic [TMO_W-1:0]        r_tmo_cnt;

  logic [DMB_BE_WIDTH-1:0] w_be;
  logic                    w_busy;
  logic                    w_timeout;
  logic                    w_hold;
  logic                    w_wr_posted;
  logic                    w_bus_req;
  logic                    w_wait;
  logic                    w_badmem;
  logic [XPR_LEN-1:0]      w_rdata;
  logic                    w_done;
  logic                    w_capture;

  vscale_dmem_be_gen u_be_gen (
    .i_wen     (i_dmem_wen),
    .i_size    (i_dmem_size),
    .i_addr_lo (i_dmem_addr[1:0]),
    .o_be      (w_be)
  );

  assign w_busy    = (r_state != DMB_ST_IDLE);
  // Counter value is (cycles spent in REQ/RESP - 1), so this fires on the
  // TIMEOUT_CYCLES-th busy cycle.
  assign w_timeout = w_busy && (r_tmo_cnt == TMO_LAST);

`ifdef VSCALE_DMEM_POSTED_WR_EN
  logic r_wr_pend;
  logic r_wr_err_sticky;

  // Registered hold: bus_req rises the cycle after the posted response.
  assign w_hold      = r_wr_pend;
  assign w_wr_posted = (r_state == DMB_ST_REQ) && !w_timeout && !w_hold &&
                       bus.bus_gnt && r_wen;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_pend       <= 1'b0;
      r_wr_err_sticky <= 1'b0;
    end else begin
      if (w_wr_posted) begin
        r_wr_pend <= 1'b1;
      end else if (bus.bus_rvalid) begin
        r_wr_pend <= 1'b0;
      end
      if (r_wr_pend && bus.bus_rvalid && bus.bus_err) begin
        r_wr_err_sticky <= 1'b1;
      end
    end
  end

  assign o_wr_err_sticky = r_wr_err_sticky;
`else
  assign w_hold          = 1'b0;
  assign w_wr_posted     = 1'b0;
  assign o_wr_err_sticky = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_bus_req   = 1'b0;
    w_wait      = 1'b0;
    w_badmem    = 1'b0;
    w_rdata     = '0;
    w_done      = 1'b0;

    case (r_state)
      DMB_ST_REQ: begin
        if (w_timeout) begin
          w_done   = 1'b1;
          w_badmem = 1'b1;
        end else if (w_wr_posted) begin
          w_bus_req = 1'b1;
          w_done    = 1'b1;
        end else begin
          w_bus_req = !w_hold;
          w_wait    = 1'b1;
          if (w_bus_req && bus.bus_gnt) begin
            w_state_nxt = DMB_ST_RESP;
          end
        end
      end
      DMB_ST_RESP: begin
        // A real response wins over a simultaneous watchdog expiry.
        if (bus.bus_rvalid) begin
          w_done   = 1'b1;
          w_rdata  = bus.bus_rdata;
          w_badmem = bus.bus_err;
        end else if (w_timeout) begin
          w_done   = 1'b1;
          w_badmem = 1'b1;
        end else begin
          w_wait = 1'b1;
        end
      end
      default: begin
      end
    endcase

    w_capture = i_dmem_en && !w_wait;
    if (w_capture) begin
      w_state_nxt = DMB_ST_REQ;
    end else if (w_done) begin
      w_state_nxt = DMB_ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= DMB_ST_IDLE;
      r_addr_hi <= '0;
      r_wen     <= 1'b0;
      r_be      <= '0;
      r_tmo_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) begin
        r_addr_hi <= i_dmem_addr[XPR_LEN-1:2];
        r_wen     <= i_dmem_wen;
        r_be      <= w_be;
      end
      if (w_capture || w_done) begin
        r_tmo_cnt <= '0;
      end else if (w_busy) begin
        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      end
    end
  end

  assign bus.bus_req   = w_bus_req;
  assign bus.bus_we    = r_wen;
  assign bus.bus_addr  = dmb_word_addr(r_addr_hi);
  assign bus.bus_be    = r_be;
  // Store data arrives in WB, which is the first REQ cycle.
  assign bus.bus_wdata = i_dmem_wdata_delayed;

  assign o_dmem_wait     = w_wait;
  assign o_dmem_rdata    = w_rdata;
  assign o_dmem_badmem_e = w_badmem;

endmodule

// File: tb/tb_vscale_dmem_bridge.sv
module tb_vscale_dmem_bridge;
  import vscale_dmem_bridge_pkg::*;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        dmem_en;
  logic        dmem_wen;
  logic [2:0]  dmem_size;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata_delayed;
  logic        dmem_wait;
  logic [31:0] dmem_rdata;
  logic        dmem_badmem_e;
  logic        wr_err_sticky;

  vscale_dmem_bridge_if bus_if ();

  vscale_dmem_bridge #(.XPR_LEN(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk                  (clk),
    .reset                (reset),
    .i_dmem_en            (dmem_en),
    .i_dmem_wen           (dmem_wen),
    .i_dmem_size          (dmem_size),
    .i_dmem_addr          (dmem_addr),
    .i_dmem_wdata_delayed (dmem_wdata_delayed),
    .o_dmem_wait          (dmem_wait),
    .o_dmem_rdata         (dmem_rdata),
    .o_dmem_badmem_e      (dmem_badmem_e),
    .o_wr_err_sticky      (wr_err_sticky),
    .bus                  (bus_if.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        badmem;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic idle_inputs();
    dmem_en               = 1'b0;
    dmem_wen              = 1'b0;
    dmem_size             = MEM_TYPE_LW;
    dmem_addr             = '0;
    dmem_wdata_delayed    = '0;
    bus_if.bus_gnt        = 1'b0;
    bus_if.bus_rvalid     = 1'b0;
    bus_if.bus_rdata      = '0;
    bus_if.bus_err        = 1'b0;
  endtask

  task automatic sb_pop(output exp_t e);
    if (sb_q.size() == 0) e = 'x;
    else e = sb_q.pop_front();
  endtask

  task automatic issue(input logic wen, input logic [2:0] size, input logic [31:0] addr);
    dmem_en   = 1'b1;
    dmem_wen  = wen;
    dmem_size = size;
    dmem_addr = addr;
  endtask

  task automatic test_reset();
    exp_t e;
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++; if (bus_if.bus_req !== 1'b0) begin n_errors++; $display("FAIL reset_bus_req: got %b want 0", bus_if.bus_req); end
    n_checks++; if (dmem_wait !== 1'b0) begin n_errors++; $display("FAIL reset_wait: got %b want 0", dmem_wait); end
    n_checks++; if (dmem_badmem_e !== 1'b0) begin n_errors++; $display("FAIL reset_badmem: got %b want 0", dmem_badmem_e); end
    n_checks++; if (dmem_rdata !== 32'h0) begin n_errors++; $display("FAIL reset_rdata: got %h want 0", dmem_rdata); end
    n_checks++; if (wr_err_sticky !== 1'b0) begin n_errors++; $display("FAIL reset_wr_err: got %b want 0", wr_err_sticky); end
    // Stray bus handshakes in IDLE must be ignored.
    @(negedge clk);
    bus_if.bus_gnt    = 1'b1;
    bus_if.bus_rvalid = 1'b1;
    bus_if.bus_rdata  = 32'hFFFF0000;
    bus_if.bus_err    = 1'b1;
    #1;
    n_checks++; if (dmem_badmem_e !== 1'b0) begin n_errors++; $display("FAIL idle_rvalid_badmem: got %b want 0", dmem_badmem_e); end
    n_checks++; if (dmem_rdata !== 32'h0) begin n_errors++; $display("FAIL idle_rvalid_rdata: got %h want 0", dmem_rdata); end
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++; if (bus_if.bus_req !== 1'b0) begin n_errors++; $display("FAIL idle_gnt_req: got %b want 0", bus_if.bus_req); end
    n_checks++; if (dmem_wait !== 1'b0) begin n_errors++; $display("FAIL idle_gnt_wait: got %b want 0", dmem_wait); end
    e = '0;
  endtask

  task automatic test_lw();
    exp_t e;
    int   stalls = 0;
    @(negedge clk);
    issue(1'b0, MEM_TYPE_LW, 32'h104);
    sb_q.push_back('{rdata: 32'hDEADBEEF, badmem: 1'b0});
    #1;
    n_checks++; if (dmem_wait !== 1'b0) begin n_errors++; $display("FAIL lw_capture_wait: got %b want 0", dmem_wait); end
    @(negedge clk);
    dmem_en = 1'b0;
    bus_if.bus_gnt = 1'b1;
    #1;
    if (dmem_wait === 1'b1) stalls++;
    n_checks++; if (bus_if.bus_req !== 1'b1) begin n_errors++; $display("FAIL lw_req: got %b want 1", bus_if.bus_req); end
    n_checks++; if (bus_if.bus_addr !== 32'h104) begin n_errors++; $display("FAIL lw_addr: got %h want 00000104", bus_if.bus_addr); end
    n_checks++; if (bus_if.bus_be !== 4'hF) begin n_errors++; $display("FAIL lw_be: got %h want f", bus_if.bus_be); end
    n_checks++; if (bus_if.bus_we !== 1'b0) begin n_errors++; $display("FAIL lw_we: got %b want 0", bus_if.bus_we); end
    @(negedge clk);
    bus_if.bus_gnt    = 1'b0;
    bus_if.bus_rvalid = 1'b1;
    bus_if.bus_rdata  = 32'hDEADBEEF;
    #1;
    if (dmem_wait === 1'b1) stalls++;
    n_checks++; if (dmem_wait !== 1'b0) begin n_errors++; $display("FAIL lw_done_wait: got %b want 0", dmem_wait); end
    sb_pop(e);
    n_checks++; if (dmem_rdata !== e.rdata) begin n_errors++; $display("FAIL lw_rdata: got %h want %h", dmem_rdata, e.rdata); end
    n_checks++; if (dmem_badmem_e !== e.badmem) begin n_errors++; $display("FAIL lw_badmem: got %b want %b", dmem_badmem_e, e.badmem); end
    n_checks++; if (stalls !== 1) begin n_errors++; $display("FAIL lw_stall_cycles: got %0d want 1", stalls); end
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++; if (bus_if.bus_req !== 1'b0) begin n_errors++; $display("FAIL lw_after_req: got %b want 0", bus_if.bus_req); end
  endtask

  task automatic test_sb_delayed_gnt();
    exp_t e;
    int   req_cycles = 0;
    int   done_seen  = 0;
    @(negedge clk);
    issue(1'b1, MEM_TYPE_SB, 32'h203);
    sb_q.push_back('{rdata: 32'h0, badmem: 1'b0});
    #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dmem_en            = 1'b0;
      dmem_wen           = 1'b0;
      dmem_wdata_delayed = 32'h5A5A5A5A;
      bus_if.bus_gnt     = (i == 3);
      #1;
      if (bus_if.bus_req === 1'b1) req_cycles++;
      if (i == 0) begin
        n_checks++; if (bus_if.bus_be !== 4'b1000) begin n_errors++; $display("FAIL sb_be: got %b want 1000", bus_if.bus_be); end
        n_checks++; if (bus_if.bus_we !== 1'b1) begin n_errors++; $display("FAIL sb_we: got %b want 1", bus_if.bus_we); end
        n_checks++; if (bus_if.bus_addr !== 32'h200) begin n_errors++; $display("FAIL sb_addr: got %h want 00000200", bus_if.bus_addr); end
        n_checks++; if (bus_if.bus_wdata !== 32'h5A5A5A5A) begin n_errors++; $display("FAIL sb_wdata: got %h want 5a5a5a5a", bus_if.bus_wdata); end
      end
      if (i < 3) begin
        n_checks++; if (dmem_wait !== 1'b1) begin n_errors++; $display("FAIL sb_stall_c%0d: got %b want 1", i, dmem_wait); end
      end else if (dmem_wait === 1'b0 && done_seen == 0) begin
        done_seen = 1;
        sb_pop(e);
        n_checks++; if (dmem_badmem_e !== e.badmem) begin n_errors++; $display("FAIL sb_posted_badmem: got %b want %b", dmem_badmem_e, e.badmem); end
      end
    end
    n_checks++; if (req_cycles !== 4) begin n_errors++; $display("FAIL sb_req_cycles: got %0d want 4", req_cycles); end
    @(negedge clk);
    bus_if.bus_gnt = 1'b0;
    #1;
    n_checks++; if (bus_if.bus_req !== 1'b0) begin n_errors++; $display("FAIL sb_req_after_gnt: got %b want 0", bus_if.bus_req); end
    n_checks++; if (dmem_wait !== (done_seen == 0)) begin n_errors++; $display("FAIL sb_wait_before_rvalid: got %b want %b", dmem_wait, done_seen == 0); end
    @(negedge clk);
    bus_if.bus_rvalid = 1'b1;
    bus_if.bus_rdata  = 32'h0;
    #1;
    n_checks++; if (dmem_wait !== 1'b0) begin n_errors++; $display("FAIL sb_wait_at_rvalid: got %b want 0", dmem_wait); end
    if (done_seen == 0) begin
      done_seen = 1;
      sb_pop(e);
      n_checks++; if (dmem_badmem_e !== e.badmem) begin n_errors++; $display("FAIL sb_badmem: got %b want %b", dmem_badmem_e, e.badmem); end
      n_checks++; if (dmem_rdata !== e.rdata) begin n_errors++; $display("FAIL sb_rdata: got %h want %h", dmem_rdata, e.rdata); end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++; if (wr_err_sticky !== 1'b0) begin n_errors++; $display("FAIL sb_wr_err: got %b want 0", wr_err_sticky); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   sh_done = 0;
    @(negedge clk);
    issue(1'b0, MEM_TYPE_LW, 32'h100);
    sb_q.push_back('{rdata: 32'h11111111, badmem: 1'b0});
    #1;
    @(negedge clk);
    issue(1'b1, MEM_TYPE_SH, 32'h10A);
    bus_if.bus_gnt = 1'b1;
    #1;
    n_checks++; if (bus_if.bus_addr !== 32'h100) begin n_errors++; $display("FAIL b2b_first_addr: got %h want 00000100", bus_if.bus_addr); end
    n_checks++; if (bus_if.bus_be !== 4'hF) begin n_errors++; $display("FAIL b2b_first_be: got %h want f", bus_if.bus_be); end
    n_checks++; if (dmem_wait !== 1'b1) begin n_errors++; $display("FAIL b2b_first_wait: got %b want 1", dmem_wait); end
    @(negedge clk);
    bus_if.bus_gnt    = 1'b0;
    bus_if.bus_rvalid = 1'b1;
    bus_if.bus_rdata  = 32'h11111111;
    sb_q.push_back('{rdata: 32'h0, badmem: 1'b0});
    #1;
    n_checks++; if (dmem_wait !== 1'b0) begin n_errors++; $display("FAIL b2b_first_done: got %b want 0", dmem_wait); end
    sb_pop(e);
    n_checks++; if (dmem_rdata !== e.rdata) begin n_errors++; $display("FAIL b2b_first_rdata: got %h want %h", dmem_rdata, e.rdata); end
    @(negedge clk);
    idle_inputs();
    dmem_wdata_delayed = 32'hBEEFBEEF;
    bus_if.bus_gnt     = 1'b1;
    #1;
    n_checks++; if (bus_if.bus_req !== 1'b1) begin n_errors++; $display("FAIL b2b_no_bubble: got %b want 1", bus_if.bus_req); end
    n_checks++; if (bus_if.bus_be !== 4'b1100) begin n_errors++; $display("FAIL b2b_sh_be: got %b want 1100", bus_if.bus_be); end
    n_checks++; if (bus_if.bus_addr !== 32'h108) begin n_errors++; $display("FAIL b2b_sh_addr: got %h want 00000108", bus_if.bus_addr); end
    n_checks++; if (bus_if.bus_we !== 1'b1) begin n_errors++; $display("FAIL b2b_sh_we: got %b want 1", bus_if.bus_we); end
    if (dmem_wait === 1'b0) begin
      sh_done = 1;
      sb_pop(e);
      n_checks++; if (dmem_badmem_e !== e.badmem) begin n_errors++; $display("FAIL b2b_sh_posted_badmem: got %b want %b", dmem_badmem_e, e.badmem); end
    end
    @(negedge clk);
    bus_if.bus_gnt    = 1'b0;
    bus_if.bus_rvalid = 1'b1;
    bus_if.bus_rdata  = 32'h0;
    #1;
    if (sh_done == 0 && dmem_wait === 1'b0) begin
      sh_done = 1;
      sb_pop(e);
      n_checks++; if (dmem_rdata !== e.rdata) begin n_errors++; $display("FAIL b2b_sh_rdata: got %h want %h", dmem_rdata, e.rdata); end
    end
    n_checks++; if (sh_done !== 1) begin n_errors++; $display("FAIL b2b_sh_complete: got %0d want 1", sh_done); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_timeout();
    exp_t e;
    int   done_cycle;
    for (int v = 0; v < 2; v++) begin
      // v=0: slave never grants; v=1: grant but no response.
      @(negedge clk);
      issue(1'b0, MEM_TYPE_LW, 32'h300 + 32'(v * 16));
      sb_q.push_back('{rdata: 32'h0, badmem: 1'b1});
      #1;
      done_cycle = 0;
      for (int c = 1; c <= TMO + 2 && done_cycle == 0; c++) begin
        @(negedge clk);
        dmem_en        = 1'b0;
        bus_if.bus_gnt = (v == 1 && c == 1);
        bus_if.bus_rdata = 32'hA5A5A5A5;
        #1;
        if (dmem_wait === 1'b0) begin
          done_cycle = c;
          sb_pop(e);
          n_checks++; if (dmem_badmem_e !== e.badmem) begin n_errors++; $display("FAIL tmo%0d_badmem: got %b want %b", v, dmem_badmem_e, e.badmem); end
          n_checks++; if (dmem_rdata !== e.rdata) begin n_errors++; $display("FAIL tmo%0d_rdata: got %h want %h", v, dmem_rdata, e.rdata); end
          n_checks++; if (bus_if.bus_req !== 1'b0) begin n_errors++; $display("FAIL tmo%0d_req: got %b want 0", v, bus_if.bus_req); end
        end else begin
          n_checks++; if (dmem_badmem_e !== 1'b0) begin n_errors++; $display("FAIL tmo%0d_early_badmem_c%0d: got %b want 0", v, c, dmem_badmem_e); end
        end
      end
      n_checks++; if (done_cycle !== TMO) begin n_errors++; $display("FAIL tmo%0d_cycle: got %0d want %0d", v, done_cycle, TMO); end
      @(negedge clk);
      bus_if.bus_rvalid = 1'b1;
      bus_if.bus_rdata  = 32'hBADBAD00;
      bus_if.bus_err    = 1'b1;
      #1;
      n_checks++; if (dmem_badmem_e !== 1'b0) begin n_errors++; $display("FAIL tmo%0d_late_badmem: got %b want 0", v, dmem_badmem_e); end
      n_checks++; if (dmem_rdata !== 32'h0) begin n_errors++; $display("FAIL tmo%0d_late_rdata: got %h want 0", v, dmem_rdata); end
      n_checks++; if (bus_if.bus_req !== 1'b0) begin n_errors++; $display("FAIL tmo%0d_idle_req: got %b want 0", v, bus_if.bus_req); end
      @(negedge clk);
      idle_inputs();
    end
  endtask

  task automatic test_err_and_reset();
    exp_t e;
    @(negedge clk);
    issue(1'b0, MEM_TYPE_LW, 32'h400);
    sb_q.push_back('{rdata: 32'h12345678, badmem: 1'b1});
    #1;
    @(negedge clk);
    dmem_en        = 1'b0;
    bus_if.bus_gnt = 1'b1;
    @(negedge clk);
    bus_if.bus_gnt    = 1'b0;
    bus_if.bus_rvalid = 1'b1;
    bus_if.bus_rdata  = 32'h12345678;
    bus_if.bus_err    = 1'b1;
    #1;
    n_checks++; if (dmem_wait !== 1'b0) begin n_errors++; $display("FAIL err_wait: got %b want 0", dmem_wait); end
    sb_pop(e);
    n_checks++; if (dmem_badmem_e !== e.badmem) begin n_errors++; $display("FAIL err_badmem: got %b want %b", dmem_badmem_e, e.badmem); end
    n_checks++; if (dmem_rdata !== e.rdata) begin n_errors++; $display("FAIL err_rdata: got %h want %h", dmem_rdata, e.rdata); end
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++; if (dmem_badmem_e !== 1'b0) begin n_errors++; $display("FAIL err_one_cycle: got %b want 0", dmem_badmem_e); end
    // Reset while waiting in RESP.
    @(negedge clk);
    issue(1'b0, MEM_TYPE_LW, 32'h500);
    @(negedge clk);
    dmem_en        = 1'b0;
    bus_if.bus_gnt = 1'b1;
    @(negedge clk);
    bus_if.bus_gnt = 1'b0;
    #1;
    n_checks++; if (dmem_wait !== 1'b1) begin n_errors++; $display("FAIL rst_pre_wait: got %b want 1", dmem_wait); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++; if (bus_if.bus_req !== 1'b0) begin n_errors++; $display("FAIL rst_mid_req: got %b want 0", bus_if.bus_req); end
    n_checks++; if (dmem_wait !== 1'b0) begin n_errors++; $display("FAIL rst_mid_wait: got %b want 0", dmem_wait); end
    @(negedge clk);
    bus_if.bus_rvalid = 1'b1;
    bus_if.bus_rdata  = 32'h55AA55AA;
    bus_if.bus_err    = 1'b1;
    #1;
    n_checks++; if (dmem_badmem_e !== 1'b0) begin n_errors++; $display("FAIL rst_drop_badmem: got %b want 0", dmem_badmem_e); end
    n_checks++; if (dmem_rdata !== 32'h0) begin n_errors++; $display("FAIL rst_drop_rdata: got %h want 0", dmem_rdata); end
    @(negedge clk);
    idle_inputs();
  endtask

`ifdef VSCALE_DMEM_POSTED_WR_EN
  task automatic test_posted();
    exp_t e;
    @(negedge clk);
    issue(1'b1, MEM_TYPE_SW, 32'h600);
    sb_q.push_back('{rdata: 32'h0, badmem: 1'b0});
    @(negedge clk);
    issue(1'b0, MEM_TYPE_LW, 32'h604);
    dmem_wdata_delayed = 32'h01020304;
    bus_if.bus_gnt     = 1'b1;
    sb_q.push_back('{rdata: 32'hCAFEF00D, badmem: 1'b0});
    #1;
    n_checks++; if (dmem_wait !== 1'b0) begin n_errors++; $display("FAIL posted_store_wait: got %b want 0", dmem_wait); end
    sb_pop(e);
    n_checks++; if (dmem_badmem_e !== e.badmem) begin n_errors++; $display("FAIL posted_store_badmem: got %b want %b", dmem_badmem_e, e.badmem); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      dmem_en        = 1'b0;
      bus_if.bus_gnt = 1'b0;
      #1;
      n_checks++; if (bus_if.bus_req !== 1'b0) begin n_errors++; $display("FAIL posted_hold_req_c%0d: got %b want 0", c, bus_if.bus_req); end
      n_checks++; if (dmem_wait !== 1'b1) begin n_errors++; $display("FAIL posted_hold_wait_c%0d: got %b want 1", c, dmem_wait); end
    end
    @(negedge clk);
    bus_if.bus_rvalid = 1'b1;
    bus_if.bus_err    = 1'b1;
    #1;
    n_checks++; if (dmem_badmem_e !== 1'b0) begin n_errors++; $display("FAIL posted_err_badmem: got %b want 0", dmem_badmem_e); end
    n_checks++; if (bus_if.bus_req !== 1'b0) begin n_errors++; $display("FAIL posted_rvalid_req: got %b want 0", bus_if.bus_req); end
    @(negedge clk);
    bus_if.bus_rvalid = 1'b0;
    bus_if.bus_err    = 1'b0;
    bus_if.bus_gnt    = 1'b1;
    #1;
    n_checks++; if (wr_err_sticky !== 1'b1) begin n_errors++; $display("FAIL posted_sticky: got %b want 1", wr_err_sticky); end
    n_checks++; if (bus_if.bus_req !== 1'b1) begin n_errors++; $display("FAIL posted_load_req: got %b want 1", bus_if.bus_req); end
    n_checks++; if (bus_if.bus_addr !== 32'h604) begin n_errors++; $display("FAIL posted_load_addr: got %h want 00000604", bus_if.bus_addr); end
    @(negedge clk);
    bus_if.bus_gnt    = 1'b0;
    bus_if.bus_rvalid = 1'b1;
    bus_if.bus_rdata  = 32'hCAFEF00D;
    #1;
    n_checks++; if (dmem_wait !== 1'b0) begin n_errors++; $display("FAIL posted_load_wait: got %b want 0", dmem_wait); end
    sb_pop(e);
    n_checks++; if (dmem_rdata !== e.rdata) begin n_errors++; $display("FAIL posted_load_rdata: got %h want %h", dmem_rdata, e.rdata); end
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++; if (wr_err_sticky !== 1'b1) begin n_errors++; $display("FAIL posted_sticky_hold: got %b want 1", wr_err_sticky); end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_lw();
    test_sb_delayed_gnt();
    test_back_to_back();
    test_timeout();
    test_err_and_reset();
`ifdef VSCALE_DMEM_POSTED_WR_EN
    test_posted();
`endif
    n_checks++;
    if (sb_q.size() !== 0) begin
      n_errors++;
      $display("FAIL scoreboard_empty: got %0d entries want 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vscale_dmem_bridge.md
Name: vscale_dmem_bridge

Overview:
Converts the core's pipelined data-memory interface into a request/grant/response bus with variable latency.
- Core side: address phase in DX; write data one cycle later in WB.
- Bus side: a single-outstanding req/gnt then rvalid protocol.
- Generates dmem_wait, dmem_rdata and dmem_badmem_e back to the core, with a watchdog for hung slaves.
- Sits directly downstream of the core pipeline's dmem port, upstream of the data SRAM or interconnect.

Parameters:
XPR_LEN, 32, data/address width (from platform constants; fixed 32).
TIMEOUT_CYCLES, 255, max cycles in REQ+RESP before forced error completion; range 1..65535.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
dmem_en  in  1  core address-phase valid (DX)
dmem_wen  in  1  core write
dmem_size  in  MEM_TYPE_WIDTH  core access type (SB/SH/SW/LB/LH/LW/LBU/LHU)
dmem_addr  in  32  core byte address
dmem_wdata_delayed  in  32  store data, valid in cycle after address phase, already lane-replicated
dmem_wait  out  1  core stall
dmem_rdata  out  32  raw aligned word; core does shift/extend
dmem_badmem_e  out  1  access fault, valid when dmem_wait=0 in data phase
bus_req  out  1  request valid
bus_gnt  in  1  request accepted
bus_we  out  1  write
bus_addr  out  32  word-aligned address ({addr[31:2],2'b00})
bus_be  out  4  byte enables
bus_wdata  out  32  write data
bus_rvalid  in  1  response valid
bus_rdata  in  32  read data
bus_err  in  1  error, qualified by bus_rvalid
wr_err_sticky  out  1  posted-write error flag (0 when optional feature is off)

Behaviour:
- Reset values: state IDLE, bus_req=0, dmem_wait=0, dmem_badmem_e=0, dmem_rdata=0, wr_err_sticky=0, timeout counter=0. All bus outputs other than bus_req are don't-care while bus_req=0.
- FSM states: IDLE, REQ, RESP.
- Capture rule: a core op is captured when dmem_en=1 && dmem_wait=0.
  - Latch addr, wen and be into registers.
  - Next state: REQ. Otherwise IDLE.
- REQ:
  - bus_req=1; bus_wdata=dmem_wdata_delayed (combinational, so valid in WB).
  - bus_gnt=1 -> RESP.
  - dmem_wait=1.
- RESP:
  - dmem_wait = ~bus_rvalid.
  - On bus_rvalid: dmem_rdata=bus_rdata and dmem_badmem_e=bus_err, both combinational in the same cycle.
  - After rvalid: capture again if dmem_en, else IDLE.
  - bus_rvalid in the same cycle as bus_gnt is illegal (earliest is the cycle after gnt).
- Minimum load latency: op in DX at N, bus_req at N+1, gnt at N+1, rvalid at N+2 → core stalled for 1 cycle.
- Byte enables:
  - SB: 4'b0001<<addr[1:0].
  - SH: 4'b0011<<{addr[1],1'b0}.
  - Word and loads of any size: 4'hF.
- Misaligned ops are not filtered here; ctrl guarantees dmem_en=0 for them.
- dmem_en while dmem_wait=1 is ignored; the core holds it stable.
- Timeout:
  - Counter increments each cycle in REQ or RESP and clears on capture or completion.
  - Reaching TIMEOUT_CYCLES: force completion with dmem_wait=0, dmem_badmem_e=1, dmem_rdata=0, bus_req=0; next state IDLE/capture.
  - A late bus_rvalid arriving after this is ignored.
- bus_rvalid or bus_gnt in IDLE is ignored.
- Reset mid-transaction: return to IDLE next cycle; the in-flight response is dropped.

Optional Feature:
Macro VSCALE_DMEM_POSTED_WR_EN.
- When defined:
  - A write completes to the core on the bus_gnt cycle (dmem_wait=0 that cycle); its response is tracked by a 1-bit pending flag.
  - A following capture enters REQ but holds bus_req=0 until the pending response arrives. The timeout counter runs during this hold.
  - A posted-write bus_err sets wr_err_sticky (cleared only by reset); dmem_badmem_e is not raised for posted writes.
- When undefined: writes wait for rvalid like loads; wr_err_sticky tied 0.

Decomposition:
- Shared header gets:
  - FSM state encodings: DMB_ST_IDLE/REQ/RESP, width 2.
  - Byte-enable width constant.
- MEM_TYPE_* constants are reused from the control constants.
- One natural sub-module: vscale_dmem_be_gen (combinational size/addr → bus_be).
- FSM and timeout stay in the top.

Test Plan:
- LW addr 0x104, gnt same cycle as req, rvalid+rdata 0xDEADBEEF next cycle → dmem_wait high exactly 1 cycle; dmem_rdata=0xDEADBEEF; bus_addr=0x104; bus_be=4'hF.
- SB addr 0x203, wdata 0x5A5A5A5A, gnt delayed 3 cycles → bus_be=4'b1000, bus_we=1, bus_req held 4 cycles, core stalled until rvalid.
- Back-to-back LW then SH at 0x10A with dmem_en held → second capture on first's rvalid cycle; bus_be=4'b1100; no idle bubble.
- Slave never responds, TIMEOUT_CYCLES=8 → dmem_badmem_e=1 and dmem_wait=0 on the 8th cycle; a later rvalid is ignored; state IDLE.
- rvalid with bus_err=1 on load → dmem_badmem_e=1 for that cycle only; reset asserted in RESP → bus_req=0 and dmem_wait=0 next cycle.
- With VSCALE_DMEM_POSTED_WR_EN: SW then LW, write response with err after 4 cycles → store stall ends at gnt; load bus_req stays low until write rvalid; wr_err_sticky=1.
